bypass_bins_ctrl: RTL

- Sequences multi-bin bypass (equiprobable) decoding for the VVC CABAC arithmetic decoder, equivalent to decodeBinsEP.
- Accepts a request for 0..MAX_BINS bins and runs the one-bin bypass step once per cycle.
- Refills the value register from the byte stream whenever the bit budget runs out, over a valid/ready handshake.
- Returns the packed bins plus the updated value and bits_needed to the context-coded decode engine.

---
 rtl/cabac_pkg.sv | 24 ++
 rtl/bypass_bin_step.sv | 33 +++
 rtl/bypass_bins_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cabac_pkg.sv
// Shared CABAC decoder definitions: FSM state encoding, bypass-path
// constants and default datapath widths.
package cabac_pkg;

  // Default datapath widths of the arithmetic decoder registers.
  localparam int DEF_VALUE_W = 32;
  localparam int DEF_RANGE_W = 9;

  // m_value carries 7 more fraction bits than m_range on the bypass path.
  localparam int RANGE_SHIFT_EP = 7;

  // m_bitsNeeded after a byte refill, and the value that forces the next refill.
  localparam logic signed [3:0] BITS_NEEDED_INIT = 4'sb1000;  // -8
  localparam logic signed [3:0] BITS_NEEDED_LAST = 4'sb1111;  // -1

  // Bypass sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    WAIT_BYTE,
    FINISH
  } state_t;

endpackage : cabac_pkg

// File: rtl/bypass_bin_step.sv
// Single bypass (equiprobable) bin decision: shift m_value left by one,
// optionally append a refill byte, then compare/subtract against range<<7.
module bypass_bin_step
  import cabac_pkg::*;
#(
  parameter int VALUE_W = DEF_VALUE_W,
  parameter int RANGE_W = DEF_RANGE_W
) (
  input  logic [VALUE_W-1:0] value,
  input  logic [RANGE_W-1:0] range,
  input  logic               refill,
  input  logic [7:0]         byte_in,
  output logic               bin,
  output logic [VALUE_W-1:0] value_next
);

  logic [VALUE_W-1:0] shifted;
  logic [VALUE_W-1:0] scaled;

  // Shift-in (plus refill byte), then the equiprobable compare/subtract.
  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    shifted    = {value[VALUE_W-2:0], 1'b0}
               + (refill ? {{(VALUE_W-8){1'b0}}, byte_in} : '0);
    scaled     = {{(VALUE_W-RANGE_W){1'b0}}, range} << RANGE_SHIFT_EP;
    bin        = (shifted >= scaled);
    // value < scaled on entry keeps shifted - scaled < scaled, so one
    // subtraction always renormalises.
    value_next = bin ? (shifted - scaled) : shifted;
  end

endmodule : bypass_bin_step

// File: rtl/bypass_bins_ctrl.sv
// Multi-bin bypass decoding sequencer (decodeBinsEP). Decodes one bin per
// cycle, stalls for a refill byte whenever m_bitsNeeded reaches -1, and
// hands back the packed bins with the updated m_value / m_bitsNeeded.
module bypass_bins_ctrl
  import cabac_pkg::*;
#(
  parameter int VALUE_W  = DEF_VALUE_W,
  parameter int RANGE_W  = DEF_RANGE_W,
  parameter int MAX_BINS = 32,
  parameter int CNT_W    = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_bins,
  input  logic [RANGE_W-1:0]        range_in,
  input  logic [VALUE_W-1:0]        value_in,
  input  logic signed [3:0]         bits_needed_in,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_in,
  output logic                      byte_ready,
  output logic                      busy,
  output logic                      done,
  output logic [MAX_BINS-1:0]       bins_out,
  output logic [VALUE_W-1:0]        value_out,
  output logic signed [3:0]         bits_needed_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BINS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state_q, state_d;
  logic [RANGE_W-1:0]  range_q, range_d;
  logic [VALUE_W-1:0]  value_q, value_d;
  logic signed [3:0]   bn_q, bn_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MAX_BINS-1:0] acc_q, acc_d;

  logic [CNT_W-1:0]    num_bins_sat;
  logic                refill;
  logic                step_bin;
  logic [VALUE_W-1:0]  step_value;

  // Requests larger than the accumulator are clipped to a full word.
  assign num_bins_sat = (num_bins > CNT_MAX) ? CNT_MAX : num_bins;

  // The byte is appended only while waiting for it; the step result is
  // committed only when byte_valid arrives.
  assign refill = (state_q == WAIT_BYTE);

  bypass_bin_step #(
    .VALUE_W (VALUE_W),
    .RANGE_W (RANGE_W)
  ) u_step (
    .value      (value_q),
    .range      (range_q),
    .refill     (refill),
    .byte_in    (byte_in),
    .bin        (step_bin),
    .value_next (step_value)
  );

  // Next-state and next-datapath logic; every register holds by default.
  always_comb begin
    state_d = state_q;
    range_d = range_q;
    value_d = value_q;
    bn_d    = bn_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          range_d = range_in;
          value_d = value_in;
          bn_d    = bits_needed_in;
          cnt_d   = num_bins_sat;
          acc_d   = '0;
          state_d = (num_bins_sat == '0) ? FINISH : DECODE;
        end
      end

      DECODE: begin
        if (bn_q == BITS_NEEDED_LAST) begin
          // Bit budget exhausted: this cycle only requests a byte.
          state_d = WAIT_BYTE;
        end else begin
          value_d = step_value;
          bn_d    = bn_q + 4'sd1;
          acc_d   = {acc_q[MAX_BINS-2:0], step_bin};
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? FINISH : DECODE;
        end
      end

      WAIT_BYTE: begin
        if (byte_valid) begin
          value_d = step_value;
          bn_d    = BITS_NEEDED_INIT;
          acc_d   = {acc_q[MAX_BINS-2:0], step_bin};
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? FINISH : DECODE;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      range_q <= '0;
      value_q <= '0;
      bn_q    <= BITS_NEEDED_INIT;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      range_q <= range_d;
      value_q <= value_d;
      bn_q    <= bn_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // Working registers double as result registers: they stop changing once
  // FINISH is reached and are only reloaded by the next accepted start.
  assign bins_out        = acc_q;
  assign value_out       = value_q;
  assign bits_needed_out = bn_q;

  assign done       = (state_q == FINISH);
  assign busy       = (state_q == DECODE) || (state_q == WAIT_BYTE);
  assign byte_ready = (state_q == WAIT_BYTE);

endmodule : bypass_bins_ctrl
